ttt_board: RTL and testbench

//  Tic-tac-toe board store and referee, the stage downstream of the game FSM.
//  - Consumes the FSM turn enables (O_play -> o_en, X_play -> x_en) and the

---
 rtl/ttt_board_if.sv | 26 ++
 rtl/ttt_board.sv | 115 +++++++++++
 tb/tb_ttt_board.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_board_if.sv
// Tic-tac-toe board bus: turn strobes and positions in, referee flags and board image out.
interface ttt_board_if #(
  parameter int PW = 4
);
  logic          clr;
  logic          o_en;
  logic          x_en;
  logic [PW-1:0] o_pos;
  logic [PW-1:0] x_pos;
  logic          illegal_move;
  logic          no_space;
  logic          win;
  logic [1:0]    winner;
  logic [3:0]    move_count;
  logic [17:0]   board;

  modport master (
    output clr, o_en, x_en, o_pos, x_pos,
    input  illegal_move, no_space, win, winner, move_count, board
  );

  modport slave (
    input  clr, o_en, x_en, o_pos, x_pos,
    output illegal_move, no_space, win, winner, move_count, board
  );
endinterface

// File: rtl/ttt_board.sv
// Tic-tac-toe board store and referee.
// Commits O/X marks from the game FSM's turn strobes into a 3x3 board, flags
// illegal moves in the same cycle as the strobe, and keeps sticky win/winner,
// no_space and move_count registered alongside the board image.
// Cell i lives in board[2i+1:2i]: 00 empty, 01 X, 10 O.
module ttt_board (
  input  logic      clk,
  input  logic      rst,
  ttt_board_if.slave bus
);
  localparam int NCELL = 9;
  localparam int PW    = 4;

  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;

  logic [17:0] board_q;
  logic [17:0] next_board;
  logic [3:0]  count_q;
  logic [3:0]  next_count;
  logic        win_q;
  logic [1:0]  winner_q;
  logic        no_space_q;
  logic [1:0]  line_sym;
  logic        o_bad;
  logic        x_bad;
  logic        o_commit;
  logic        x_commit;

  // A move is bad when it points off the board, at an occupied cell, or the game is won.
  function automatic logic is_bad(input logic [PW-1:0] p, input logic [17:0] b,
                                  input logic w);
    logic occ;
    occ = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      if (p == PW'(i) && b[2*i +: 2] != 2'b00) occ = 1'b1;
    end
    return (p > PW'(8)) || occ || w;
  endfunction

  // Returns the symbol owning a line of three cells, or 00 if the line is not complete.
  function automatic logic [1:0] line_owner(input logic [17:0] b, input int a,
                                            input int c, input int d);
    logic [1:0] sa;
    logic [1:0] sc;
    logic [1:0] sd;
    sa = b[2*a +: 2];
    sc = b[2*c +: 2];
    sd = b[2*d +: 2];
    if (sa != 2'b00 && sa == sc && sc == sd) return sa;
    return 2'b00;
  endfunction

  // Judge the pending strobes against the current board and build the next board.
  always_comb begin
    o_bad      = is_bad(bus.o_pos, board_q, win_q);
    x_bad      = is_bad(bus.x_pos, board_q, win_q);
    o_commit   = bus.o_en & ~bus.x_en & ~o_bad;
    x_commit   = bus.x_en & ~bus.o_en & ~x_bad;
    next_board = board_q;
    next_count = count_q;
    for (int i = 0; i < NCELL; i++) begin
      if (o_commit && bus.o_pos == PW'(i)) next_board[2*i +: 2] = MARK_O;
      if (x_commit && bus.x_pos == PW'(i)) next_board[2*i +: 2] = MARK_X;
    end
    if ((o_commit || x_commit) && count_q != 4'd9) next_count = count_q + 4'd1;
  end

  // Scan all eight lines of the next board so the referee has no lag behind board.
  always_comb begin
    line_sym = 2'b00;
    if (line_sym == 2'b00) line_sym = line_owner(next_board, 0, 1, 2);
    if (line_sym == 2'b00) line_sym = line_owner(next_board, 3, 4, 5);
    if (line_sym == 2'b00) line_sym = line_owner(next_board, 6, 7, 8);
    if (line_sym == 2'b00) line_sym = line_owner(next_board, 0, 3, 6);
    if (line_sym == 2'b00) line_sym = line_owner(next_board, 1, 4, 7);
    if (line_sym == 2'b00) line_sym = line_owner(next_board, 2, 5, 8);
    if (line_sym == 2'b00) line_sym = line_owner(next_board, 0, 4, 8);
    if (line_sym == 2'b00) line_sym = line_owner(next_board, 2, 4, 6);
  end

  // Register board, count and referee flags; clr wins over any strobe, win is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_q    <= '0;
      count_q    <= '0;
      win_q      <= 1'b0;
      winner_q   <= 2'b00;
      no_space_q <= 1'b0;
    end else if (bus.clr) begin
      board_q    <= '0;
      count_q    <= '0;
      win_q      <= 1'b0;
      winner_q   <= 2'b00;
      no_space_q <= 1'b0;
    end else begin
      board_q    <= next_board;
      count_q    <= next_count;
      no_space_q <= (next_count == 4'd9);
      if (!win_q && line_sym != 2'b00) begin
        win_q    <= 1'b1;
        winner_q <= line_sym;
      end
    end
  end

  assign bus.illegal_move = (bus.o_en & ~bus.x_en & o_bad)
                          | (bus.x_en & ~bus.o_en & x_bad)
                          | (bus.o_en & bus.x_en);
  assign bus.board      = board_q;
  assign bus.move_count = count_q;
  assign bus.win        = win_q;
  assign bus.winner     = winner_q;
  assign bus.no_space   = no_space_q;
endmodule

// File: tb/tb_ttt_board.sv
// Self-checking bench for ttt_board: a cell-array game model checked every cycle,
// plus directed game scenarios with literal expectations.
module tb_ttt_board;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ttt_board_if bus ();

  ttt_board dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  // Game model: one integer per cell (0 empty, 1 X, 2 O), sticky winner.
  int mcells [9];
  bit model_win;
  int model_winner;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit model_bad(input logic [3:0] p);
    if (p > 4'd8) return 1'b1;
    if (model_win) return 1'b1;
    return mcells[int'(p)] != 0;
  endfunction

  function automatic int model_owner(input int c [9]);
    for (int l = 0; l < 8; l++) begin
      if (c[lines[l][0]] != 0 && c[lines[l][0]] == c[lines[l][1]] &&
          c[lines[l][1]] == c[lines[l][2]])
        return c[lines[l][0]];
    end
    return 0;
  endfunction

  function automatic logic [17:0] exp_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mcells[i]);
    return b;
  endfunction

  function automatic int exp_count();
    int n;
    n = 0;
    for (int i = 0; i < 9; i++) if (mcells[i] != 0) n++;
    return n;
  endfunction

  function automatic logic exp_illegal();
    return (bus.o_en && bus.x_en) ||
           (bus.o_en && !bus.x_en && model_bad(bus.o_pos)) ||
           (bus.x_en && !bus.o_en && model_bad(bus.x_pos));
  endfunction

  task automatic checkOutput(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on every clock edge from the strobes the DUT also sees.
  always @(posedge clk or posedge rst) begin : model_step
    int c [9];
    bit w;
    int wn;
    if (rst || bus.clr) begin
      for (int i = 0; i < 9; i++) mcells[i] <= 0;
      model_win    <= 1'b0;
      model_winner <= 0;
    end else begin
      c  = mcells;
      w  = model_win;
      wn = model_winner;
      if (bus.o_en && !bus.x_en && !model_bad(bus.o_pos)) c[int'(bus.o_pos)] = 2;
      else if (bus.x_en && !bus.o_en && !model_bad(bus.x_pos)) c[int'(bus.x_pos)] = 1;
      if (!w) begin
        wn = model_owner(c);
        w  = (wn != 0);
      end
      mcells       <= c;
      model_win    <= w;
      model_winner <= wn;
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (check_en && !rst) begin
      checkOutput("board", bus.board, exp_board());
      checkOutput("move_count", 18'(bus.move_count), 18'(exp_count()));
      checkOutput("win", 18'(bus.win), 18'(model_win));
      checkOutput("winner", 18'(bus.winner), 18'(model_winner));
      checkOutput("no_space", 18'(bus.no_space), 18'(exp_count() == 9));
      checkOutput("illegal_move", 18'(bus.illegal_move), 18'(exp_illegal()));
    end
  end

  // Drive one cycle of strobes; optionally pin illegal_move to a literal in-cycle.
  task automatic applyStimulus(input logic oe, input logic xe, input logic [3:0] op,
                               input logic [3:0] xp, input logic c, input bit chk,
                               input logic exp_ill);
    bus.o_en  = oe;
    bus.x_en  = xe;
    bus.o_pos = op;
    bus.x_pos = xp;
    bus.clr   = c;
    #2;
    if (chk) checkOutput("illegal_lit", 18'(bus.illegal_move), 18'(exp_ill));
    @(posedge clk);
    #1;
    bus.o_en  = 1'b0;
    bus.x_en  = 1'b0;
    bus.o_pos = '0;
    bus.x_pos = '0;
    bus.clr   = 1'b0;
  endtask

  task automatic playO(input logic [3:0] p);
    applyStimulus(1'b1, 1'b0, p, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic playX(input logic [3:0] p);
    applyStimulus(1'b0, 1'b1, 4'd0, p, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.clr   = 1'b0;
    bus.o_en  = 1'b0;
    bus.x_en  = 1'b0;
    bus.o_pos = '0;
    bus.x_pos = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_en = 1'b1;

    checkOutput("rst_board", bus.board, 18'd0);
    checkOutput("rst_count", 18'(bus.move_count), 18'd0);
    checkOutput("rst_win", 18'(bus.win), 18'd0);
    checkOutput("rst_no_space", 18'(bus.no_space), 18'd0);

    // First legal O move to the centre
    applyStimulus(1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("o4_cell", 18'(bus.board[9:8]), 18'(2'b10));
    checkOutput("o4_count", 18'(bus.move_count), 18'd1);

    // X onto the occupied centre is rejected
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd4, 1'b0, 1'b1, 1'b1);
    checkOutput("x4_cell", 18'(bus.board[9:8]), 18'(2'b10));
    checkOutput("x4_count", 18'(bus.move_count), 18'd1);

    // Off-board positions and simultaneous strobes
    applyStimulus(1'b1, 1'b0, 4'd9, 4'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd15, 4'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b1);
    checkOutput("bad_count", 18'(bus.move_count), 18'd1);
    checkOutput("bad_board", bus.board, 18'h00200);

    // New-game clear overrides a legal O strobe to cell 5
    applyStimulus(1'b1, 1'b0, 4'd5, 4'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_board", bus.board, 18'd0);
    checkOutput("clr_count", 18'(bus.move_count), 18'd0);

    // O wins on the main diagonal, then the board freezes
    playO(4'd0); playX(4'd1); playO(4'd4); playX(4'd2); playO(4'd8);
    checkOutput("diag_win", 18'(bus.win), 18'd1);
    checkOutput("diag_winner", 18'(bus.winner), 18'(2'b10));
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 1'b1);
    checkOutput("frozen_board", bus.board, 18'b100000001000010110);
    checkOutput("frozen_count", 18'(bus.move_count), 18'd5);
    checkOutput("win_sticky", 18'(bus.win), 18'd1);

    // Draw game fills the board
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    playO(4'd0); playX(4'd1); playO(4'd2); playX(4'd4); playO(4'd3);
    playX(4'd5); playO(4'd7); playX(4'd6); playO(4'd8);
    checkOutput("draw_no_space", 18'(bus.no_space), 18'd1);
    checkOutput("draw_win", 18'(bus.win), 18'd0);
    checkOutput("draw_count", 18'(bus.move_count), 18'd9);
    checkOutput("draw_board", bus.board, 18'b101001010110100110);
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("full_count", 18'(bus.move_count), 18'd9);

    // Held strobe: the repeat attempt hits an occupied cell
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("hold_count", 18'(bus.move_count), 18'd1);

    // Async reset between edges while a move is pending
    bus.o_en  = 1'b1;
    bus.o_pos = 4'd6;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_board", bus.board, 18'd0);
    checkOutput("arst_count", 18'(bus.move_count), 18'd0);
    checkOutput("arst_win", 18'(bus.win), 18'd0);
    bus.o_en  = 1'b0;
    bus.o_pos = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("arst_lost", bus.board, 18'd0);

    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
